// File: rtl/wb_arbiter.sv
// Two-requester Wishbone arbiter: round-robin on ties, no preemption,
// and a per-transfer ack timeout that aborts the owner through a DRAIN state.
module wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        m0_cyc_in,
  input  logic        m0_stb_in,
  input  logic        m0_we_in,
  input  logic [31:0] m0_addr_in,
  input  logic [31:0] m0_wdata_in,
  input  logic [3:0]  m0_sel_in,
  output logic        m0_ack_out,
  output logic        m0_err_out,
  output logic [31:0] m0_rdata_out,
  input  logic        m1_cyc_in,
  input  logic        m1_stb_in,
  input  logic        m1_we_in,
  input  logic [31:0] m1_addr_in,
  input  logic [31:0] m1_wdata_in,
  input  logic [3:0]  m1_sel_in,
  output logic        m1_ack_out,
  output logic        m1_err_out,
  output logic [31:0] m1_rdata_out,
  output logic        s_cyc_out,
  output logic        s_stb_out,
  output logic        s_we_out,
  output logic [31:0] s_addr_out,
  output logic [31:0] s_wdata_out,
  output logic [3:0]  s_sel_out,
  input  logic        s_ack_in,
  input  logic [31:0] s_rdata_in,
  output logic [1:0]  grant_out,
  output logic [1:0]  fsm_state_out
);

  // Handshake: a transfer is pending while s_stb_out is high; it completes in
  // any cycle where s_ack_in is also high. No ready/backpressure beyond that.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;  // 1 = m1 owned the bus last
  logic [15:0] wait_cnt;
  logic        g0, g1, waiting, timeout, owner_cyc;

  assign g0        = (state == GRANT0);
  assign g1        = (state == GRANT1);
  assign waiting   = s_stb_out & ~s_ack_in;
  assign timeout   = waiting & (wait_cnt == LIMIT);
  // In DRAIN the owner is still the requester recorded on grant entry.
  assign owner_cyc = last_grant ? m1_cyc_in : m0_cyc_in;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= 16'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= waiting ? wait_cnt + 16'd1 : 16'd0;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_cyc_in && (!m1_cyc_in || last_grant)) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc_in) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
        end
      end
      GRANT0: begin
        if (timeout)         state_nxt = DRAIN;
        else if (!m0_cyc_in) state_nxt = IDLE;
      end
      GRANT1: begin
        if (timeout)         state_nxt = DRAIN;
        else if (!m1_cyc_in) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!owner_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_out   = 1'b0;
    s_stb_out   = 1'b0;
    s_we_out    = 1'b0;
    s_addr_out  = 32'd0;
    s_wdata_out = 32'd0;
    s_sel_out   = 4'd0;
    if (g0) begin
      s_cyc_out   = m0_cyc_in;
      s_stb_out   = m0_stb_in;
      s_we_out    = m0_we_in;
      s_addr_out  = m0_addr_in;
      s_wdata_out = m0_wdata_in;
      s_sel_out   = m0_sel_in;
    end else if (g1) begin
      s_cyc_out   = m1_cyc_in;
      s_stb_out   = m1_stb_in;
      s_we_out    = m1_we_in;
      s_addr_out  = m1_addr_in;
      s_wdata_out = m1_wdata_in;
      s_sel_out   = m1_sel_in;
    end
  end

  assign m0_ack_out    = g0 & s_ack_in;
  assign m1_ack_out    = g1 & s_ack_in;
  assign m0_err_out    = g0 & timeout;
  assign m1_err_out    = g1 & timeout;
  assign m0_rdata_out  = g0 ? s_rdata_in : 32'd0;
  assign m1_rdata_out  = g1 ? s_rdata_in : 32'd0;
  assign grant_out     = {g1, g0};
  assign fsm_state_out = state;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: tie-break, round-robin, timeout abort,
// ack-at-limit priority, late ack in DRAIN, and asynchronous reset mid-transfer.
module tb_wb_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        m0_cyc_in, m0_stb_in, m0_we_in;
  logic [31:0] m0_addr_in, m0_wdata_in;
  logic [3:0]  m0_sel_in;
  logic        m0_ack_out, m0_err_out;
  logic [31:0] m0_rdata_out;
  logic        m1_cyc_in, m1_stb_in, m1_we_in;
  logic [31:0] m1_addr_in, m1_wdata_in;
  logic [3:0]  m1_sel_in;
  logic        m1_ack_out, m1_err_out;
  logic [31:0] m1_rdata_out;
  logic        s_cyc_out, s_stb_out, s_we_out;
  logic [31:0] s_addr_out, s_wdata_out;
  logic [3:0]  s_sel_out;
  logic        s_ack_in;
  logic [31:0] s_rdata_in;
  logic [1:0]  grant_out;
  logic [1:0]  fsm_state_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .m0_cyc_in(m0_cyc_in), .m0_stb_in(m0_stb_in), .m0_we_in(m0_we_in),
    .m0_addr_in(m0_addr_in), .m0_wdata_in(m0_wdata_in), .m0_sel_in(m0_sel_in),
    .m0_ack_out(m0_ack_out), .m0_err_out(m0_err_out), .m0_rdata_out(m0_rdata_out),
    .m1_cyc_in(m1_cyc_in), .m1_stb_in(m1_stb_in), .m1_we_in(m1_we_in),
    .m1_addr_in(m1_addr_in), .m1_wdata_in(m1_wdata_in), .m1_sel_in(m1_sel_in),
    .m1_ack_out(m1_ack_out), .m1_err_out(m1_err_out), .m1_rdata_out(m1_rdata_out),
    .s_cyc_out(s_cyc_out), .s_stb_out(s_stb_out), .s_we_out(s_we_out),
    .s_addr_out(s_addr_out), .s_wdata_out(s_wdata_out), .s_sel_out(s_sel_out),
    .s_ack_in(s_ack_in), .s_rdata_in(s_rdata_in),
    .grant_out(grant_out), .fsm_state_out(fsm_state_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  // Driver tasks: inputs change 2 time units after a rising edge,
  // and outputs are sampled 1 unit after that.
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int idx, input logic cyc, input logic stb);
    if (idx == 0) begin m0_cyc_in = cyc; m0_stb_in = stb; end
    else          begin m1_cyc_in = cyc; m1_stb_in = stb; end
  endtask

  logic [31:0] all_out;
  assign all_out = {m0_ack_out, m0_err_out, m1_ack_out, m1_err_out, s_cyc_out,
                    s_stb_out, s_we_out, grant_out, fsm_state_out} |
                   m0_rdata_out | m1_rdata_out | s_addr_out | s_wdata_out |
                   {28'd0, s_sel_out};

  initial begin
    reset_in = 1'b0;
    m0_cyc_in = 0; m0_stb_in = 0; m0_we_in = 0; m0_addr_in = 0; m0_wdata_in = 0; m0_sel_in = 0;
    m1_cyc_in = 0; m1_stb_in = 0; m1_we_in = 0; m1_addr_in = 0; m1_wdata_in = 0; m1_sel_in = 0;
    s_ack_in = 0; s_rdata_in = 0;
    settle();
    chk("reset_all_out", all_out, 32'd0);
    tick(); tick();
    reset_in = 1'b1;

    // Tie after reset goes to m0; read returns slave data to m0 only.
    m0_cyc_in = 1; m1_cyc_in = 1;
    settle();
    chk("tie_idle_grant", {30'd0, grant_out}, 32'd0);
    tick();
    chk("tie_grant_m0", {30'd0, grant_out}, 32'd1);
    chk("tie_s_cyc", {31'd0, s_cyc_out}, 32'd1);
    m0_stb_in = 1; m0_addr_in = 32'h10; s_ack_in = 1; s_rdata_in = 32'hDEADBEEF;
    settle();
    chk("rd_m0_ack", {31'd0, m0_ack_out}, 32'd1);
    chk("rd_m0_rdata", m0_rdata_out, 32'hDEADBEEF);
    chk("rd_m1_ack", {31'd0, m1_ack_out}, 32'd0);
    chk("rd_m1_rdata", m1_rdata_out, 32'd0);
    chk("rd_s_addr", s_addr_out, 32'h10);
    tick();
    m0_stb_in = 0; s_ack_in = 0; m0_cyc_in = 0;
    settle();
    chk("drop_s_cyc", {31'd0, s_cyc_out}, 32'd0);
    tick();
    chk("drop_idle", {30'd0, grant_out}, 32'd0);
    tick();
    chk("then_m1", {30'd0, grant_out}, 32'd2);
    m1_cyc_in = 0;
    tick();

    // Round robin: both keep requesting, each owner releases after one transfer.
    m0_cyc_in = 1; m1_cyc_in = 1;
    for (int i = 0; i < 8; i++) begin
      int owner;
      owner = i % 2;
      settle();
      chk("rr_idle", {30'd0, grant_out}, 32'd0);
      tick();
      chk("rr_grant", {30'd0, grant_out}, (owner == 0) ? 32'd1 : 32'd2);
      set_m(owner, 1'b1, 1'b1);
      s_ack_in = 1; s_rdata_in = 32'hA000_0000 + 32'(i);
      settle();
      chk("rr_owner_ack", {31'd0, (owner == 0) ? m0_ack_out : m1_ack_out}, 32'd1);
      chk("rr_other_ack", {31'd0, (owner == 0) ? m1_ack_out : m0_ack_out}, 32'd0);
      tick();
      set_m(owner, 1'b0, 1'b0);
      s_ack_in = 0;
      tick();
      set_m(owner, 1'b1, 1'b0);
    end
    m0_cyc_in = 0; m1_cyc_in = 0;
    tick();

    // Timeout: m1 strobes, slave silent; err pulses 8 cycles after the strobe is sampled.
    m1_cyc_in = 1; m1_stb_in = 1; m1_addr_in = 32'h200;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("to_err", {31'd0, m1_err_out}, (k == 8) ? 32'd1 : 32'd0);
      chk("to_grant", {30'd0, grant_out}, 32'd2);
    end
    tick();
    chk("drain_err_gone", {31'd0, m1_err_out}, 32'd0);
    chk("drain_s_cyc", {31'd0, s_cyc_out}, 32'd0);
    chk("drain_state", {30'd0, fsm_state_out}, {30'd0, ST_DRAIN});
    s_ack_in = 1; m0_cyc_in = 1;
    settle();
    chk("drain_late_ack_m1", {31'd0, m1_ack_out}, 32'd0);
    chk("drain_late_ack_m0", {31'd0, m0_ack_out}, 32'd0);
    tick();
    chk("drain_holds", {30'd0, fsm_state_out}, {30'd0, ST_DRAIN});
    chk("drain_no_grant", {30'd0, grant_out}, 32'd0);
    s_ack_in = 0; m1_cyc_in = 0; m1_stb_in = 0;
    tick();
    chk("drain_exit", {30'd0, fsm_state_out}, {30'd0, ST_IDLE});
    tick();
    chk("post_drain_m0", {30'd0, grant_out}, 32'd1);
    m0_cyc_in = 0;
    tick();

    // Ack arriving exactly at the limit wins over the timeout.
    m1_cyc_in = 1; m1_stb_in = 1;
    for (int k = 1; k <= 8; k++) tick();
    s_ack_in = 1;
    settle();
    chk("lim_ack", {31'd0, m1_ack_out}, 32'd1);
    chk("lim_err", {31'd0, m1_err_out}, 32'd0);
    tick();
    s_ack_in = 0; m1_stb_in = 0;
    settle();
    chk("lim_grant_held", {30'd0, grant_out}, 32'd2);
    m1_cyc_in = 0;
    tick();
    tick();

    // Reset pulsed mid-wait on an m0 write.
    m0_cyc_in = 1; m0_stb_in = 1; m0_we_in = 1; m0_addr_in = 32'h100;
    m0_sel_in = 4'b0011; m0_wdata_in = 32'h1234_5678;
    tick();
    chk("wr_addr", s_addr_out, 32'h100);
    chk("wr_sel", {28'd0, s_sel_out}, 32'h3);
    chk("wr_we", {31'd0, s_we_out}, 32'd1);
    chk("wr_wdata", s_wdata_out, 32'h1234_5678);
    tick(); tick();
    reset_in = 0; s_ack_in = 1;
    settle();
    chk("rst_s_cyc", {31'd0, s_cyc_out}, 32'd0);
    chk("rst_all_out", all_out, 32'd0);
    tick();
    chk("rst_hold_all_out", all_out, 32'd0);
    s_ack_in = 0; m0_stb_in = 0; m0_we_in = 0; m1_cyc_in = 1;
    reset_in = 1;
    tick();
    chk("rst_tie_m0", {30'd0, grant_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
